// File: rtl/rca4_seq_adder_ctrl.sv
// rca4_seq_adder_ctrl: WIDTH-bit add over one 4-bit ripple slice, one nibble per cycle; define RCA_SEQ_SUB_EN to add op_sub (a-b)
module rca4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] c;
  assign c[0] = c_i;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign c_o = c[4];
endmodule

module rca4_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
  if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_bad_width
    $error("rca4_seq_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d, sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d, sub_q, sub_d, sub_in;
  logic [3:0]       a_n, b_n, s_n;
  logic             c_n, last;
`ifdef RCA_SEQ_SUB_EN
  assign sub_in = op_sub;
`else
  assign sub_in = 1'b0;
`endif
  assign a_n  = a_q[4*idx_q +: 4];
  assign b_n  = sub_q ? ~b_q[4*idx_q +: 4] : b_q[4*idx_q +: 4];
  assign last = idx_q == IW'(NIB - 1);
  rca4 u_slice (.a_i(a_n), .b_i(b_n), .c_i(carry_q), .s_o(s_n), .c_o(c_n));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    sub_d   = sub_q;
    if (state_q == RUN) begin
      part_d[4*idx_q +: 4] = s_n;
      carry_d = c_n;
      idx_d   = idx_q + IW'(1);
      if (last) begin
        sum_d   = part_d;
        cout_d  = c_n;
        state_d = DONE;
      end
    end else if (start) begin
      a_d     = a;
      b_d     = b;
      sub_d   = sub_in;
      carry_d = sub_in | cin;
      idx_d   = '0;
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      sub_q   <= sub_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
